// File: rtl/multi_ch_sync.sv
// multi_ch_sync: per-channel STAGES-flop synchroniser with registered edge strobes.
// Optional debounce filter compiled in by defining MULTI_CH_SYNC_DEBOUNCE_EN.
module multi_ch_sync #(
    parameter int CH         = 4,
    parameter int STAGES     = 2,
    parameter int DEB_CYCLES = 4,
    parameter bit RESET_VAL  = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] async_in,
    output logic [CH-1:0] sync_out,
    output logic [CH-1:0] rise_pulse,
    output logic [CH-1:0] fall_pulse,
    output logic          change_any
);

    localparam logic [CH-1:0] RST_VEC = {CH{RESET_VAL}};

    logic [STAGES-1:0][CH-1:0] chain_q, chain_d;
    logic [CH-1:0]             prev_q, prev_d;
    logic [CH-1:0]             rise_q, rise_d;
    logic [CH-1:0]             fall_q, fall_d;
    logic                      change_q, change_d;
    logic [CH-1:0]             last;

    assign last = chain_q[STAGES-1];

    // Pure shift chain: stage 0 takes the raw input, no logic between stages.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VEC}};
        end else begin
            chain_q <= chain_d;
        end
    end

`ifdef MULTI_CH_SYNC_DEBOUNCE_EN
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]         sync_q, sync_d;

    always_comb begin
        cnt_d  = cnt_q;
        sync_d = sync_q;
        for (int i = 0; i < CH; i++) begin
            if (last[i] == sync_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sync_d[i] = last[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sync_q <= RST_VEC;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;
`else
    assign sync_out = last;
`endif

    always_comb begin
        prev_d   = sync_out;
        rise_d   = sync_out & ~prev_q;
        fall_d   = ~sync_out & prev_q;
        change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= RST_VEC;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign change_any = change_q;

endmodule

// File: tb/tb_multi_ch_sync.sv
// tb_multi_ch_sync: directed self-checking bench for multi_ch_sync (CH=4, STAGES=2).
// Debounce scenarios run when MULTI_CH_SYNC_DEBOUNCE_EN is defined.
module tb_multi_ch_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       change_any;

    int n_chk  = 0;
    int n_pass = 0;

    multi_ch_sync #(
        .CH        (4),
        .STAGES    (2),
        .DEB_CYCLES(4),
        .RESET_VAL (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .sync_out  (sync_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .change_any(change_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge, sample 1ns later, and guard rise/fall exclusivity.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("no_overlap", 32'(rise_pulse & fall_pulse), 32'h0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef MULTI_CH_SYNC_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    initial begin
        rst      = 1'b1;
        async_in = 4'b0000;
        ticks(2);
        chk("rst_sync", 32'(sync_out), 32'h0);
        chk("rst_rise", 32'(rise_pulse), 32'h0);
        chk("rst_fall", 32'(fall_pulse), 32'h0);
        chk("rst_chg", 32'(change_any), 32'h0);
        rst = 1'b0;
        tick();
        chk("rel_rise", 32'(rise_pulse), 32'h0);
        ticks(3);

`ifndef MULTI_CH_SYNC_DEBOUNCE_EN
        // Single-bit rise: visible after E+1, strobe after E+2.
        async_in = 4'b0001;
        tick();
        chk("b0_sync_E", 32'(sync_out), 32'h0);
        tick();
        chk("b0_sync_E1", 32'(sync_out), 32'h1);
        chk("b0_rise_E1", 32'(rise_pulse), 32'h0);
        tick();
        chk("b0_rise_E2", 32'(rise_pulse), 32'h1);
        chk("b0_chg_E2", 32'(change_any), 32'h1);
        chk("b0_fall_E2", 32'(fall_pulse), 32'h0);
        tick();
        chk("b0_rise_E3", 32'(rise_pulse), 32'h0);
        chk("b0_chg_E3", 32'(change_any), 32'h0);
        async_in = 4'b0000;
        ticks(2);
        tick();
        chk("b0_fall", 32'(fall_pulse), 32'h1);
        ticks(3);

        // Two channels rising and falling together.
        async_in = 4'b1010;
        ticks(2);
        chk("mc_sync", 32'(sync_out), 32'ha);
        tick();
        chk("mc_rise", 32'(rise_pulse), 32'ha);
        chk("mc_fall0", 32'(fall_pulse), 32'h0);
        chk("mc_chg", 32'(change_any), 32'h1);
        tick();
        chk("mc_rise_gone", 32'(rise_pulse), 32'h0);
        async_in = 4'b0000;
        ticks(2);
        chk("mc_sync0", 32'(sync_out), 32'h0);
        tick();
        chk("mc_fall", 32'(fall_pulse), 32'ha);
        chk("mc_rise0", 32'(rise_pulse), 32'h0);
        tick();
        chk("mc_fall_gone", 32'(fall_pulse), 32'h0);
        ticks(2);
`else
        // Three-cycle glitch on bit 2 must be filtered out.
        async_in = 4'b0100;
        ticks(3);
        async_in = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("gl_sync", 32'(sync_out), 32'h0);
            chk("gl_chg", 32'(change_any), 32'h0);
        end

        // Bit 1 held six cycles: accepted after four cycles at last stage.
        async_in = 4'b0010;
        ticks(5);
        chk("db_sync_E4", 32'(sync_out), 32'h0);
        tick();
        chk("db_sync_E5", 32'(sync_out), 32'h2);
        chk("db_rise_E5", 32'(rise_pulse), 32'h0);
        async_in = 4'b0000;
        tick();
        chk("db_rise_E6", 32'(rise_pulse), 32'h2);
        chk("db_chg_E6", 32'(change_any), 32'h1);
        tick();
        chk("db_rise_E7", 32'(rise_pulse), 32'h0);
        ticks(8);
        chk("db_sync_back", 32'(sync_out), 32'h0);
        ticks(2);
`endif

        // Reset two cycles into a debounce window with all inputs high.
        async_in = 4'b1111;
        ticks(4);
        rst = 1'b1;
        tick();
        chk("mid_rst_sync", 32'(sync_out), 32'h0);
        chk("mid_rst_rise", 32'(rise_pulse), 32'h0);
        chk("mid_rst_chg", 32'(change_any), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rel_rise", 32'(rise_pulse), 32'h0);
        chk("post_rel_chg", 32'(change_any), 32'h0);
        ticks(LAT - 2);
        chk("refill_sync_early", 32'(sync_out), 32'h0);
        tick();
        chk("refill_sync", 32'(sync_out), 32'hf);
        tick();
        chk("refill_rise", 32'(rise_pulse), 32'hf);
        chk("refill_chg", 32'(change_any), 32'h1);
        tick();
        chk("refill_rise_gone", 32'(rise_pulse), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
